// File: rtl/nrisc_pkg.sv
// rtl/nrisc_pkg.sv - shared nRisc types and constants
package nrisc_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } mem_state_t;

   localparam int NRISC_W           = 8;
   localparam int NRISC_MEM_TIMEOUT = 16;

endpackage

// File: rtl/nrisc_timeout_cnt.sv
// rtl/nrisc_timeout_cnt.sv - saturating clear/enable counter with terminal-count flag
module nrisc_timeout_cnt #(
   parameter int W    = 5,
   parameter int TERM = 15
) (
   input  logic clk,
   input  logic resetn,
   input  logic clr,
   input  logic en,
   output logic tc
);

   logic [W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en && (cnt != '1)) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign tc = (cnt == W'(TERM));

endmodule

// File: rtl/nrisc_mem_ctrl.sv
// rtl/nrisc_mem_ctrl.sv - nRisc data-memory req/ack bus controller with core stall
module nrisc_mem_ctrl
   import nrisc_pkg::*;
#(
   parameter int                 DATA_W   = NRISC_W,
   parameter int                 TIMEOUT  = NRISC_MEM_TIMEOUT,
   parameter logic [DATA_W-1:0]  ERR_DATA = 8'hFF
) (
   input  logic              Clock,
   input  logic              reset,
   input  logic              MemRead,
   input  logic              MemWrite,
   input  logic [DATA_W-1:0] Endereco,
   input  logic [DATA_W-1:0] DadoEscrita,
   output logic [DATA_W-1:0] LeDado,
   output logic              Stall,
   output logic              Erro,
   output logic              mem_req,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack
);

   localparam int CNT_W = $clog2(TIMEOUT) + 1;

   generate
      if (TIMEOUT < 2) begin : g_bad_timeout
         $error("nrisc_mem_ctrl: TIMEOUT must be at least 2");
      end
   endgenerate

   mem_state_t        state, next_state;
   logic [DATA_W-1:0] rdata_q;
   logic              acc;
   logic              tc;

   assign acc     = MemRead | MemWrite;
   assign mem_req = (state == BUSY);
   assign LeDado  = rdata_q;

   nrisc_timeout_cnt #(
      .W    (CNT_W),
      .TERM (TIMEOUT - 1)
   ) u_timeout_cnt (
      .clk    (Clock),
      .resetn (reset),
      .clr    (state == IDLE),
      .en     ((state == BUSY) && !mem_ack),
      .tc     (tc)
   );

   always_ff @(posedge Clock) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Stall must follow the strobes combinationally in IDLE so the core never slips past an access.
   always_comb begin
      next_state = state;
      Stall      = 1'b0;
      case (state)
         IDLE: begin
            Stall = acc;
            if (acc) next_state = BUSY;
         end
         BUSY: begin
            Stall = 1'b1;
            if (mem_ack || tc) next_state = DONE;
         end
         DONE: next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge Clock) begin
      if (!reset) begin
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         rdata_q   <= '0;
         Erro      <= 1'b0;
      end else begin
         Erro <= 1'b0;
         if ((state == IDLE) && acc) begin
            mem_addr  <= Endereco;
            mem_wdata <= DadoEscrita;
            mem_we    <= MemWrite;
            Erro      <= MemRead & MemWrite;
         end
         // A late ack on the terminal cycle still wins over the timeout.
         if (state == BUSY) begin
            if (mem_ack) begin
               if (!mem_we) rdata_q <= mem_rdata;
            end else if (tc) begin
               if (!mem_we) rdata_q <= ERR_DATA;
               Erro <= 1'b1;
            end
         end
      end
   end

endmodule
